// File: rtl/lms_fir_datapath.sv
// rtl/lms_fir_datapath.sv - three-tap adaptive FIR datapath feeding the LMS coefficient updater
//
// Purpose:
//   Each accepted sample shifts a 3-deep delay line.
//   The sample is filtered with the live coefficients h0..h2.
//   The block returns y, the error e = d - y, and the taps aligned with e.
//   Arithmetic is signed Q(NB_DATA-NBF_DATA).NBF_DATA with saturation.
//   Pipeline: stage A (delay line), stage B (products), stage C (sum/error/outputs).
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_valid, i_x, i_d     input sample qualifier, input sample, desired sample
//   i_h0, i_h1, i_h2      coefficients, sampled in stage B
//   o_x0, o_x1, o_x2      taps aligned with o_error (x0 newest), 0 when idle
//   o_y                   filter output, holds between results
//   o_error               d - y when warm, otherwise 0
//   o_valid               one-cycle strobe per result
//   o_warm                delay line has held 3 genuine samples since reset
module lms_fir_datapath #(
  parameter int NB_DATA  = 32,
  parameter int NBF_DATA = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_x,
  input  logic [NB_DATA-1:0] i_d,
  input  logic [NB_DATA-1:0] i_h0,
  input  logic [NB_DATA-1:0] i_h1,
  input  logic [NB_DATA-1:0] i_h2,
  output logic [NB_DATA-1:0] o_x0,
  output logic [NB_DATA-1:0] o_x1,
  output logic [NB_DATA-1:0] o_x2,
  output logic [NB_DATA-1:0] o_y,
  output logic [NB_DATA-1:0] o_error,
  output logic               o_valid,
  output logic               o_warm
);

  localparam int NB  = NB_DATA;
  localparam int NBF = NBF_DATA;

  localparam logic [NB-1:0] MAX_V = {1'b0, {(NB-1){1'b1}}};
  localparam logic [NB-1:0] MIN_V = {1'b1, {(NB-1){1'b0}}};

  // The value fits in NB bits when all bits from the NB-1 sign position up are equal.
  function automatic logic [NB-1:0] sat_prod(input logic signed [2*NB-1:0] v);
    logic [NB:0] top;
    top = v[2*NB-1:NB-1];
    if ((&top) || !(|top)) return v[NB-1:0];
    return v[2*NB-1] ? MIN_V : MAX_V;
  endfunction

  function automatic logic [NB-1:0] sat_sum(input logic [NB+1:0] v);
    logic [2:0] top;
    top = v[NB+1:NB-1];
    if ((&top) || !(|top)) return v[NB-1:0];
    return v[NB+1] ? MIN_V : MAX_V;
  endfunction

  function automatic logic [NB-1:0] sat_err(input logic [NB:0] v);
    if (v[NB] == v[NB-1]) return v[NB-1:0];
    return v[NB] ? MIN_V : MAX_V;
  endfunction

  // Stage A state
  logic [NB-1:0] t0_q, t1_q, t2_q, da_q;
  logic [NB-1:0] t0_d, t1_d, t2_d, da_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          va_q, va_d;

  // Stage B state
  logic [NB-1:0] p0_q, p1_q, p2_q, bx0_q, bx1_q, bx2_q, db_q;
  logic [NB-1:0] p0_d, p1_d, p2_d, bx0_d, bx1_d, bx2_d, db_d;
  logic          wb_q, wb_d, vb_q, vb_d;

  // Stage C / output state
  logic [NB-1:0] y_q, err_q, ox0_q, ox1_q, ox2_q;
  logic [NB-1:0] y_d, err_d, ox0_d, ox1_d, ox2_d;
  logic          ov_q, ov_d, warm_q, warm_d;

  // Combinational intermediates
  logic signed [2*NB-1:0] prod0, prod1, prod2;
  logic [NB+1:0]          sum_w;
  logic [NB-1:0]          y_c;
  logic [NB:0]            err_w;

  always_comb begin
    // Stage A: shift only on an accepted sample; the counter saturates at 3.
    t0_d  = t0_q;
    t1_d  = t1_q;
    t2_d  = t2_q;
    da_d  = da_q;
    cnt_d = cnt_q;
    va_d  = i_valid;
    if (i_valid) begin
      t0_d = i_x;
      t1_d = t0_q;
      t2_d = t1_q;
      da_d = i_d;
      if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
    end

    // Stage B: full-width products, arithmetic shift (floor), then saturate.
    prod0 = $signed({{NB{t0_q[NB-1]}}, t0_q}) * $signed({{NB{i_h0[NB-1]}}, i_h0});
    prod1 = $signed({{NB{t1_q[NB-1]}}, t1_q}) * $signed({{NB{i_h1[NB-1]}}, i_h1});
    prod2 = $signed({{NB{t2_q[NB-1]}}, t2_q}) * $signed({{NB{i_h2[NB-1]}}, i_h2});
    p0_d  = p0_q;
    p1_d  = p1_q;
    p2_d  = p2_q;
    bx0_d = bx0_q;
    bx1_d = bx1_q;
    bx2_d = bx2_q;
    db_d  = db_q;
    wb_d  = wb_q;
    vb_d  = va_q;
    if (va_q) begin
      p0_d  = sat_prod(prod0 >>> NBF);
      p1_d  = sat_prod(prod1 >>> NBF);
      p2_d  = sat_prod(prod2 >>> NBF);
      bx0_d = t0_q;
      bx1_d = t1_q;
      bx2_d = t2_q;
      db_d  = da_q;
      wb_d  = (cnt_q == 2'd3);
    end

    // Stage C: two guard bits hold the sum of three NB-bit terms exactly.
    sum_w = {{2{p0_q[NB-1]}}, p0_q} + {{2{p1_q[NB-1]}}, p1_q} + {{2{p2_q[NB-1]}}, p2_q};
    y_c   = sat_sum(sum_w);
    err_w = {db_q[NB-1], db_q} - {y_c[NB-1], y_c};

    // Idle cycles present zero error and zero taps so the updater leaves h alone.
    y_d    = y_q;
    err_d  = '0;
    ox0_d  = '0;
    ox1_d  = '0;
    ox2_d  = '0;
    ov_d   = vb_q;
    warm_d = warm_q;
    if (vb_q) begin
      y_d    = y_c;
      err_d  = wb_q ? sat_err(err_w) : '0;
      ox0_d  = bx0_q;
      ox1_d  = bx1_q;
      ox2_d  = bx2_q;
      warm_d = warm_q | wb_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      t0_q   <= '0;
      t1_q   <= '0;
      t2_q   <= '0;
      da_q   <= '0;
      cnt_q  <= '0;
      va_q   <= 1'b0;
      p0_q   <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      bx0_q  <= '0;
      bx1_q  <= '0;
      bx2_q  <= '0;
      db_q   <= '0;
      wb_q   <= 1'b0;
      vb_q   <= 1'b0;
      y_q    <= '0;
      err_q  <= '0;
      ox0_q  <= '0;
      ox1_q  <= '0;
      ox2_q  <= '0;
      ov_q   <= 1'b0;
      warm_q <= 1'b0;
    end else begin
      t0_q   <= t0_d;
      t1_q   <= t1_d;
      t2_q   <= t2_d;
      da_q   <= da_d;
      cnt_q  <= cnt_d;
      va_q   <= va_d;
      p0_q   <= p0_d;
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      bx0_q  <= bx0_d;
      bx1_q  <= bx1_d;
      bx2_q  <= bx2_d;
      db_q   <= db_d;
      wb_q   <= wb_d;
      vb_q   <= vb_d;
      y_q    <= y_d;
      err_q  <= err_d;
      ox0_q  <= ox0_d;
      ox1_q  <= ox1_d;
      ox2_q  <= ox2_d;
      ov_q   <= ov_d;
      warm_q <= warm_d;
    end
  end

  assign o_x0    = ox0_q;
  assign o_x1    = ox1_q;
  assign o_x2    = ox2_q;
  assign o_y     = y_q;
  assign o_error = err_q;
  assign o_valid = ov_q;
  assign o_warm  = warm_q;

endmodule

// File: tb/tb_lms_fir_datapath.sv
// tb/tb_lms_fir_datapath.sv - scoreboard bench for lms_fir_datapath
module tb_lms_fir_datapath;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_x = '0, i_d = '0, i_h0 = '0, i_h1 = '0, i_h2 = '0;
  logic [31:0] o_x0, o_x1, o_x2, o_y, o_error;
  logic        o_valid, o_warm;

  lms_fir_datapath #(.NB_DATA(32), .NBF_DATA(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_x(i_x), .i_d(i_d),
    .i_h0(i_h0), .i_h1(i_h1), .i_h2(i_h2),
    .o_x0(o_x0), .o_x1(o_x1), .o_x2(o_x2), .o_y(o_y), .o_error(o_error),
    .o_valid(o_valid), .o_warm(o_warm)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] y, e, x0, x1, x2;
    logic        warm;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: recent samples newest-first and count since reset.
  logic [31:0] hist[3];
  int          nsamp;
  logic        pend_v;
  logic [31:0] pend_t[3];
  logic [31:0] pend_d;
  logic        pend_w;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] MAXV = 32'h7FFF_FFFF;
  localparam logic [31:0] MINV = 32'h8000_0000;

  function automatic logic [31:0] clamp(input longint v);
    if (v > 64'sd2147483647) return MAXV;
    if (v < -64'sd2147483648) return MINV;
    return v[31:0];
  endfunction

  function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return clamp(p >>> 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus. The coefficients driven now are the ones
  // stage B uses for the sample accepted on the previous edge.
  task automatic cycle(input logic v, input logic [31:0] x, input logic [31:0] d,
                       input logic [31:0] h0, input logic [31:0] h1, input logic [31:0] h2);
    exp_t   ex;
    longint s;
    i_valid = v; i_x = x; i_d = d; i_h0 = h0; i_h1 = h1; i_h2 = h2;
    if (pend_v) begin
      s = longint'($signed(fx_mul(pend_t[0], h0))) + longint'($signed(fx_mul(pend_t[1], h1)))
        + longint'($signed(fx_mul(pend_t[2], h2)));
      ex.y    = clamp(s);
      ex.e    = pend_w ? clamp(longint'($signed(pend_d)) - longint'($signed(ex.y))) : 32'h0;
      ex.x0   = pend_t[0];
      ex.x1   = pend_t[1];
      ex.x2   = pend_t[2];
      ex.warm = pend_w;
      sb.push_back(ex);
      pend_v = 1'b0;
    end
    if (v) begin
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = x;
      if (nsamp < 3) nsamp++;
      pend_t = hist;
      pend_d = d;
      pend_w = (nsamp == 3);
      pend_v = 1'b1;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, $urandom, i_h0, i_h1, i_h2);
  endtask

  // Asserted between edges; outputs must clear before any further edge.
  task automatic async_reset();
    #2;
    i_rst = 1'b1;
    i_valid = 1'b0;
    sb.delete();
    pend_v = 1'b0;
    hist = '{32'h0, 32'h0, 32'h0};
    nsamp = 0;
    #1;
    chk("rst_valid", {31'h0, o_valid}, 32'h0);
    chk("rst_y", o_y, 32'h0);
    chk("rst_error", o_error, 32'h0);
    chk("rst_taps", o_x0 | o_x1 | o_x2, 32'h0);
    chk("rst_warm", {31'h0, o_warm}, 32'h0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic impulse();
    cycle(1'b1, ONE,   32'h0, ONE, 32'h0000_8000, 32'h0000_4000);
    cycle(1'b1, 32'h0, 32'h0, ONE, 32'h0000_8000, 32'h0000_4000);
    cycle(1'b1, 32'h0, 32'h0, ONE, 32'h0000_8000, 32'h0000_4000);
    cycle(1'b1, 32'h0, 32'h0, ONE, 32'h0000_8000, 32'h0000_4000);
    idle(3);
  endtask

  // Monitor: pops on every strobe, checks idle-state outputs otherwise.
  initial begin : monitor
    exp_t        ex;
    logic [31:0] last_y;
    logic        exp_warm;
    last_y = '0;
    exp_warm = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        last_y = '0;
        exp_warm = 1'b0;
      end else if (o_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {31'h0, o_valid}, 32'h0);
        end else begin
          ex = sb.pop_front();
          exp_warm = exp_warm | ex.warm;
          last_y = ex.y;
          chk("y", o_y, ex.y);
          chk("error", o_error, ex.e);
          chk("x0", o_x0, ex.x0);
          chk("x1", o_x1, ex.x1);
          chk("x2", o_x2, ex.x2);
          chk("warm", {31'h0, o_warm}, {31'h0, exp_warm});
        end
      end else begin
        chk("idle_error", o_error, 32'h0);
        chk("idle_taps", o_x0 | o_x1 | o_x2, 32'h0);
        chk("idle_y_hold", o_y, last_y);
        chk("idle_warm", {31'h0, o_warm}, {31'h0, exp_warm});
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] h[3];
    logic        v;
    hist = '{32'h0, 32'h0, 32'h0};
    nsamp = 0;
    pend_v = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    idle(2);
    async_reset();
    idle(10);

    impulse();

    // Product and sum saturation, then error saturation in both directions.
    for (int i = 0; i < 4; i++) cycle(1'b1, MAXV, 32'h0, MAXV, MAXV, MAXV);
    cycle(1'b1, MAXV, MINV, MAXV, MAXV, MAXV);
    cycle(1'b0, MAXV, MINV, MAXV, MAXV, MAXV);
    cycle(1'b1, MAXV, MAXV, MAXV, MAXV, MAXV);
    cycle(1'b0, 32'h0, 32'h0, MINV, MINV, MINV);
    idle(3);

    // Valid gaps from a fresh reset.
    async_reset();
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, ONE * i, $urandom, 32'h0, 32'h0, 32'h0);
      idle(2);
    end
    idle(2);

    // Reset with two samples in flight; impulse must replay from scratch.
    cycle(1'b1, 32'h0003_0000, 32'h1234, ONE, ONE, ONE);
    cycle(1'b1, 32'h0004_0000, 32'h5678, ONE, ONE, ONE);
    async_reset();
    impulse();

    // Randomized streaming with live coefficient changes.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 3))
          0: h[k] = $urandom;
          1: h[k] = $urandom_range(0, 32'h0002_0000) - 32'h0001_0000;
          2: h[k] = ($urandom_range(0, 1) != 0) ? MAXV : MINV;
          default: h[k] = $urandom_range(0, 32'h0000_FFFF);
        endcase
      end
      v = ($urandom_range(0, 3) != 0);
      cycle(v, ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 32'h0004_0000) - 32'h0002_0000,
            $urandom, h[0], h[1], h[2]);
      if (i == 200) async_reset();
    end
    idle(5);
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
